fb_access_arbiter: RTL

FB_ACCESS_ARBITER -- requirements
Module: fb_access_arbiter

---
 rtl/fb_pkg.sv | 30 +++
 rtl/paint_fifo.sv | 58 +++++
 rtl/fb_access_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// Shared frame-buffer types: resolution defaults, FSM states, queued paint entry and
// the pixel-address helper.
package fb_pkg;

   localparam int H_RES     = 640;
   localparam int V_RES     = 480;
   localparam int COLOR_W   = 3;
   localparam int FB_ADDR_W = 19;
   localparam int COORD_W   = 10;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } fb_state_t;

   typedef logic [FB_ADDR_W-1:0] fb_addr_t;

   typedef struct packed {
      fb_addr_t           addr;
      logic [COLOR_W-1:0] color;
   } paint_entry_t;

   // Row-major linear address; the product is deliberately truncated to FB_ADDR_W.
   function automatic fb_addr_t pix_addr(input logic [COORD_W-1:0] x,
                                         input logic [COORD_W-1:0] y,
                                         input int h_res);
      return fb_addr_t'(y) * fb_addr_t'(h_res) + fb_addr_t'(x);
   endfunction

endpackage

// File: rtl/paint_fifo.sv
// Synchronous FIFO of pending paint writes; head entry is visible combinationally, pop is
// seen the same cycle. A push while full is taken only if a pop happens in that cycle.
module paint_fifo
   import fb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         push,
   input  paint_entry_t push_entry,
   input  logic         pop,
   output paint_entry_t head_entry,
   output logic         full,
   output logic         empty
);

   localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);

   paint_entry_t     slots [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             do_push;
   logic             do_pop;

   assign full       = (count == FULL_CNT);
   assign empty      = (count == '0);
   assign do_pop     = pop && !empty;
   assign do_push    = push && (!full || do_pop);
   assign head_entry = slots[rd_ptr];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: the pointers decide which slots are meaningful.
   always_ff @(posedge clk) begin
      if (do_push) slots[wr_ptr] <= push_entry;
   end

endmodule

// File: rtl/fb_access_arbiter.sv
// Single-port frame-buffer arbiter: scanout read > clear fill > queued paint write, one access
// per cycle, address combinational; display is never stalled, paints drop when the queue is full.
module fb_access_arbiter
   import fb_pkg::*;
#(
   parameter int H_RES      = fb_pkg::H_RES,
   parameter int V_RES      = fb_pkg::V_RES,
   parameter int COLOR_W    = fb_pkg::COLOR_W,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 disp_req,
   input  logic [9:0]           disp_x,
   input  logic [9:0]           disp_y,
   output logic                 disp_valid,
   output logic [COLOR_W-1:0]   disp_data,
   input  logic                 paint_req,
   input  logic [9:0]           paint_x,
   input  logic [9:0]           paint_y,
   input  logic [COLOR_W-1:0]   paint_color,
   input  logic                 clear_req,
   input  logic [COLOR_W-1:0]   clear_color,
   output logic                 busy,
   output logic                 paint_drop,
   output logic [FB_ADDR_W-1:0] mem_addr,
   output logic                 mem_we,
   output logic [COLOR_W-1:0]   mem_wdata,
   input  logic [COLOR_W-1:0]   mem_rdata
);

   localparam fb_addr_t    LAST_ADDR = fb_addr_t'(H_RES * V_RES - 1);
   localparam fb_addr_t    ADDR_ONE  = fb_addr_t'(1);
   localparam logic [10:0] X_LIM     = 11'(H_RES);
   localparam logic [10:0] Y_LIM     = 11'(V_RES);

   fb_state_t          state_q, state_d;
   fb_addr_t           clear_addr_q, clear_addr_d;
   logic [COLOR_W-1:0] clear_color_q, clear_color_d;
   fb_addr_t           addr_hold_q;
   logic               paint_req_q;
   logic [9:0]         last_x_q, last_y_q;
   logic               disp_valid_q;

   paint_entry_t       fifo_head;
   paint_entry_t       new_entry;
   logic               fifo_full, fifo_empty, fifo_pop;
   logic               in_range, coord_new, enq_try, enq_push;

   // An enqueue is attempted on a press edge or a cursor move; a dropped attempt still
   // becomes the reference coordinate so a held button cannot pulse paint_drop every cycle.
   assign in_range  = ({1'b0, paint_x} < X_LIM) && ({1'b0, paint_y} < Y_LIM);
   assign coord_new = !paint_req_q || (paint_x != last_x_q) || (paint_y != last_y_q);
   assign enq_try   = paint_req && coord_new && in_range;
   assign fifo_pop  = (state_q == IDLE) && !disp_req && !fifo_empty;
   assign enq_push  = enq_try && (!fifo_full || fifo_pop);
   assign paint_drop = enq_try && fifo_full && !fifo_pop;

   assign new_entry.addr  = pix_addr(paint_x, paint_y, H_RES);
   assign new_entry.color = paint_color;

   paint_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_paint_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (enq_push),
      .push_entry(new_entry),
      .pop       (fifo_pop),
      .head_entry(fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_comb begin
      state_d       = state_q;
      clear_addr_d  = clear_addr_q;
      clear_color_d = clear_color_q;
      mem_we        = 1'b0;
      mem_addr      = addr_hold_q;
      mem_wdata     = '0;

      if (disp_req) begin
         mem_addr = pix_addr(disp_x, disp_y, H_RES);
      end else if (state_q == CLEAR) begin
         mem_we    = 1'b1;
         mem_addr  = clear_addr_q;
         mem_wdata = clear_color_q;
      end else if (!fifo_empty) begin
         mem_we    = 1'b1;
         mem_addr  = fifo_head.addr;
         mem_wdata = fifo_head.color;
      end

      case (state_q)
         IDLE: begin
            if (clear_req) begin
               state_d       = CLEAR;
               clear_addr_d  = '0;
               clear_color_d = clear_color;
            end
         end
         CLEAR: begin
            if (!disp_req) begin
               if (clear_addr_q == LAST_ADDR) state_d = IDLE;
               else                           clear_addr_d = clear_addr_q + ADDR_ONE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Memory port is quiet the moment reset asserts, even with inputs still active.
      if (!reset_n) begin
         mem_we    = 1'b0;
         mem_addr  = '0;
         mem_wdata = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         clear_addr_q  <= '0;
         clear_color_q <= '0;
         addr_hold_q   <= '0;
         paint_req_q   <= 1'b0;
         last_x_q      <= '0;
         last_y_q      <= '0;
         disp_valid_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         clear_addr_q  <= clear_addr_d;
         clear_color_q <= clear_color_d;
         addr_hold_q   <= mem_addr;
         paint_req_q   <= paint_req;
         disp_valid_q  <= disp_req;
         if (enq_try) begin
            last_x_q <= paint_x;
            last_y_q <= paint_y;
         end
      end
   end

   assign busy       = (state_q == CLEAR);
   assign disp_valid = disp_valid_q;
   assign disp_data  = reset_n ? mem_rdata : '0;

endmodule
